// File: rtl/wb8_interconnect_pkg.sv
// Shared definitions for the 8-bit Wishbone interconnect: FSM state
// encodings, the value returned on an error ack and the address window width.
package wb8_interconnect_pkg;

  localparam int WIN_W = 32;

  localparam logic [7:0] ERR_DAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } ic_state_t;

endpackage

// File: rtl/wb8_ic_match.sv
// Address window compare and priority encoder for the Wishbone interconnect.
// Produces one hit bit per slave window; the lowest-numbered hit is
// reported as the selected slave.
module wb8_ic_match
  import wb8_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W = 2,
  parameter logic [WIN_W*NUM_SLAVES-1:0] SLV_BASE = '0,
  parameter logic [WIN_W*NUM_SLAVES-1:0] SLV_MASK = '0
)(
  input  logic [WIN_W-1:0]      adr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [SEL_W-1:0]      sel,
  output logic                  any_hit
);

  // A window hits when every masked address bit equals the base bit.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = ((adr ^ SLV_BASE[WIN_W*i +: WIN_W]) & SLV_MASK[WIN_W*i +: WIN_W]) == '0;
    end
  end

  // Scan from the top down so the lowest-numbered hit is the last one kept.
  always_comb begin
    sel = '0;
    any_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel = SEL_W'(i);
        any_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb8_interconnect.sv
// N-slave address decoder and router for the 8-bit Wishbone bus.
// Routes the master to one slave with zero added latency, latches the
// selected slave for multi-cycle transfers, and terminates stuck transfers
// with an error ack while capturing the first faulting address.
// Optional feature macro: WB8_INTERCONNECT_UNMAPPED_ERR_EN -- when defined,
// addresses that match no window get an error ack instead of going to
// DEFAULT_SLAVE.
module wb8_interconnect
  import wb8_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [WIN_W*NUM_SLAVES-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [WIN_W*NUM_SLAVES-1:0] SLV_MASK = {NUM_SLAVES{32'h0}},
  parameter int DEFAULT_SLAVE = 0,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                    I_wb_clk,
  input  logic                    I_reset_n,
  input  logic [WIN_W-1:0]        I_wb_adr,
  input  logic                    I_wb_stb,
  input  logic                    I_wb_we,
  output logic [7:0]              O_wb_dat,
  output logic                    O_wb_ack,
  output logic                    O_wb_stall,
  output logic                    O_wb_err,
  output logic [NUM_SLAVES-1:0]   O_slv_stb,
  input  logic [8*NUM_SLAVES-1:0] I_slv_dat,
  input  logic [NUM_SLAVES-1:0]   I_slv_ack,
  input  logic [NUM_SLAVES-1:0]   I_slv_stall,
  output logic                    O_fault_valid,
  output logic [WIN_W-1:0]        O_fault_adr,
  output logic                    O_fault_we,
  input  logic                    I_fault_clr
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ic_state_t            state;
  logic [SEL_W-1:0]     lat_sel;
  logic [CNT_W-1:0]     count;
  logic [WIN_W-1:0]     lat_adr;
  logic                 lat_we;

  // The raw hit vector is not needed for routing; it stays visible for debug.
  logic [NUM_SLAVES-1:0] hit_unused;
  logic [SEL_W-1:0]      match_sel;
  logic                  any_hit;
  logic [SEL_W-1:0]      sel_idle;
  logic [SEL_W-1:0]      cur_sel;
  logic                  unmapped;

  wb8_ic_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_match (
    .adr     (I_wb_adr),
    .hit     (hit_unused),
    .sel     (match_sel),
    .any_hit (any_hit)
  );

  // Pick the slave: live decode while idle, the latched one mid-transfer.
  always_comb begin
    sel_idle = any_hit ? match_sel : SEL_W'(DEFAULT_SLAVE);
`ifdef WB8_INTERCONNECT_UNMAPPED_ERR_EN
    unmapped = ~any_hit;
`else
    unmapped = 1'b0;
`endif
    cur_sel = (state == BUSY) ? lat_sel : sel_idle;
  end

  // Master and slave side outputs; the error cycle overrides routing.
  always_comb begin
    O_wb_dat   = '0;
    O_wb_ack   = 1'b0;
    O_wb_stall = 1'b0;
    O_wb_err   = 1'b0;
    O_slv_stb  = '0;
    if (state == ERR) begin
      O_wb_dat = ERR_DAT;
      O_wb_ack = 1'b1;
      O_wb_err = 1'b1;
    end else if (I_wb_stb && !(state == IDLE && unmapped)) begin
      O_slv_stb[cur_sel] = 1'b1;
      O_wb_dat   = I_slv_dat[8*cur_sel +: 8];
      O_wb_ack   = I_slv_ack[cur_sel];
      O_wb_stall = I_slv_stall[cur_sel];
    end
  end

  // Transfer FSM, watchdog counter and sticky fault capture.
  always_ff @(posedge I_wb_clk) begin
    if (!I_reset_n) begin
      state         <= IDLE;
      count         <= '0;
      lat_sel       <= SEL_W'(DEFAULT_SLAVE);
      lat_adr       <= '0;
      lat_we        <= 1'b0;
      O_fault_valid <= 1'b0;
      O_fault_adr   <= '0;
      O_fault_we    <= 1'b0;
    end else begin
      if (I_fault_clr) begin
        O_fault_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (I_wb_stb) begin
            if (unmapped) begin
              lat_adr <= I_wb_adr;
              lat_we  <= I_wb_we;
              state   <= ERR;
            end else if (!I_slv_ack[sel_idle]) begin
              lat_sel <= sel_idle;
              lat_adr <= I_wb_adr;
              lat_we  <= I_wb_we;
              count   <= CNT_W'(1);
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!I_wb_stb || I_slv_ack[lat_sel]) begin
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
            if (count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              state <= ERR;
            end
          end
        end
        ERR: begin
          state <= IDLE;
          if (!O_fault_valid || I_fault_clr) begin
            O_fault_valid <= 1'b1;
            O_fault_adr   <= lat_adr;
            O_fault_we    <= lat_we;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb8_interconnect.sv
// Testbench for wb8_interconnect: table of single-cycle routing vectors,
// hand-written multi-cycle sequences, and a scoreboard of expected acks.
module tb_wb8_interconnect;

  localparam int NS = 4;
  localparam logic [32*NS-1:0] BASE      = {32'h00000000, 32'hFFFFF800, 32'hFFFFF000, 32'hFFFF0000};
  localparam logic [32*NS-1:0] MASK      = {32'hFF000000, 32'hFFFFFF00, 32'hFFFFF800, 32'hFFFFE000};
  localparam logic [32*NS-1:0] MASK_WIDE = {32'hFF000000, 32'hFFFFFF00, 32'hFFFFF000, 32'hFFFFE000};
`ifdef WB8_INTERCONNECT_UNMAPPED_ERR_EN
  localparam logic [31:0] TO_ADR = 32'h00800000;
`else
  localparam logic [31:0] TO_ADR = 32'h80000000;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] adr;
  logic        stb;
  logic        we;
  logic [3:0]  slv_ack;
  logic [3:0]  slv_stall;
  logic        fault_clr;
  logic [31:0] slv_dat = {8'hD3, 8'hC2, 8'h5A, 8'hA0};

  logic [7:0]  dat;
  logic        ack, stall, err;
  logic [3:0]  slv_stb;
  logic        fault_valid, fault_we;
  logic [31:0] fault_adr;

  logic [7:0]  dat2;
  logic        ack2, stall2, err2;
  logic [3:0]  slv_stb2;
  logic        fault_valid2, fault_we2;
  logic [31:0] fault_adr2;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] dat;
    logic       err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic        stb;
    logic [3:0]  ack;
    logic [3:0]  stall;
    logic [3:0]  exp_stb;
    logic        exp_ack;
    logic [7:0]  exp_dat;
    logic        exp_stall;
  } vec_t;
  vec_t vecs[$];

  wb8_interconnect #(
    .NUM_SLAVES(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
    .DEFAULT_SLAVE(3), .TIMEOUT_CYCLES(255)
  ) dut (
    .I_wb_clk(clk), .I_reset_n(reset_n), .I_wb_adr(adr), .I_wb_stb(stb),
    .I_wb_we(we), .O_wb_dat(dat), .O_wb_ack(ack), .O_wb_stall(stall),
    .O_wb_err(err), .O_slv_stb(slv_stb), .I_slv_dat(slv_dat),
    .I_slv_ack(slv_ack), .I_slv_stall(slv_stall), .O_fault_valid(fault_valid),
    .O_fault_adr(fault_adr), .O_fault_we(fault_we), .I_fault_clr(fault_clr)
  );

  wb8_interconnect #(
    .NUM_SLAVES(NS), .SLV_BASE(BASE), .SLV_MASK(MASK_WIDE),
    .DEFAULT_SLAVE(3), .TIMEOUT_CYCLES(255)
  ) dut_wide (
    .I_wb_clk(clk), .I_reset_n(reset_n), .I_wb_adr(adr), .I_wb_stb(stb),
    .I_wb_we(we), .O_wb_dat(dat2), .O_wb_ack(ack2), .O_wb_stall(stall2),
    .O_wb_err(err2), .O_slv_stb(slv_stb2), .I_slv_dat(slv_dat),
    .I_slv_ack(slv_ack), .I_slv_stall(slv_stall), .O_fault_valid(fault_valid2),
    .O_fault_adr(fault_adr2), .O_fault_we(fault_we2), .I_fault_clr(fault_clr)
  );

  // Free-running bus clock.
  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic s, input logic w,
                               input logic [3:0] k, input logic [3:0] st);
    adr = a;
    stb = s;
    we = w;
    slv_ack = k;
    slv_stall = st;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string n, input logic [31:0] a, input logic s, input logic [3:0] k,
                        input logic [3:0] st, input logic [3:0] es, input logic ea,
                        input logic [7:0] ed, input logic est);
    vec_t v;
    v.name = n; v.adr = a; v.stb = s; v.ack = k; v.stall = st;
    v.exp_stb = es; v.exp_ack = ea; v.exp_dat = ed; v.exp_stall = est;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    fault_clr = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives a transfer nobody acks and expects the error ack on exp_cycle.
  task automatic runTimeout(input logic [31:0] a, input logic w, input int exp_cycle,
                            input bit clr_on_err, input string name);
    int cyc;
    cyc = 0;
    nextCycle();
    applyStimulus(a, 1'b1, w, 4'b0000, 4'b0000);
    sbq.push_back('{8'hFF, 1'b1});
    for (int c = 1; c <= exp_cycle + 40; c++) begin
      if (c > 1) nextCycle();
      @(negedge clk);
      if (ack === 1'b1) begin
        cyc = c;
        break;
      end
    end
    checkOutput({name, "_cycle"}, cyc, exp_cycle);
    if (cyc != 0) begin
      checkOutput({name, "_err_stb"}, {28'h0, slv_stb}, 32'h0);
      checkOutput({name, "_err_stall"}, {31'h0, stall}, 32'h0);
    end else begin
      sbq.delete();
    end
    if (clr_on_err) fault_clr = 1'b1;
    nextCycle();
    fault_clr = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
  endtask

  // Scoreboard: every master ack must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_ack: got ack with dat %h, expected no ack", dat);
      end else begin
        e = sbq.pop_front();
        checkOutput("sb_dat", {24'h0, dat}, {24'h0, e.dat});
        checkOutput("sb_err", {31'h0, err}, {31'h0, e.err});
      end
    end
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    addVec("rd_s1_same",  32'hFFFFF004, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 8'h5A, 1'b0);
    addVec("idle_nostb",  32'hFFFFF004, 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 8'h00, 1'b0);
    addVec("rd_s0_same",  32'hFFFF1234, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 8'hA0, 1'b0);
    addVec("rd_s2_same",  32'hFFFFF8AB, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1, 8'hC2, 1'b0);
    addVec("rd_s3_win",   32'h00123456, 1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b1, 8'hD3, 1'b0);
    addVec("stall_sel",   32'hFFFFF004, 1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 8'h5A, 1'b1);
    addVec("stall_unsel", 32'hFFFF1234, 1'b1, 4'b0001, 4'b1110, 4'b0001, 1'b1, 8'hA0, 1'b0);
    addVec("w0_top_edge", 32'hFFFF1FFF, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 8'hA0, 1'b0);
    addVec("w1_top_edge", 32'hFFFFF7FF, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 8'h5A, 1'b0);
`ifndef WB8_INTERCONNECT_UNMAPPED_ERR_EN
    addVec("w0_past_end", 32'hFFFF2000, 1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b1, 8'hD3, 1'b0);
    addVec("unmap_dflt",  32'h40000000, 1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b1, 8'hD3, 1'b0);
`endif

    doReset();
    checkOutput("rst_ack", {31'h0, ack}, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_stb", {28'h0, slv_stb}, 32'h0);
    checkOutput("rst_dat", {24'h0, dat}, 32'h0);
    checkOutput("rst_fault_valid", {31'h0, fault_valid}, 32'h0);
    checkOutput("rst_fault_adr", fault_adr, 32'h0);
    checkOutput("rst_fault_we", {31'h0, fault_we}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      nextCycle();
      applyStimulus(vecs[i].adr, vecs[i].stb, 1'b0, vecs[i].ack, vecs[i].stall);
      if (vecs[i].exp_ack) sbq.push_back('{vecs[i].exp_dat, 1'b0});
      @(negedge clk);
      checkOutput({vecs[i].name, "_stb"}, {28'h0, slv_stb}, {28'h0, vecs[i].exp_stb});
      checkOutput({vecs[i].name, "_ack"}, {31'h0, ack}, {31'h0, vecs[i].exp_ack});
      checkOutput({vecs[i].name, "_dat"}, {24'h0, dat}, {24'h0, vecs[i].exp_dat});
      checkOutput({vecs[i].name, "_stall"}, {31'h0, stall}, {31'h0, vecs[i].exp_stall});
    end
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Overlapping windows: the widened window 1 beats window 2.
    doReset();
    nextCycle();
    applyStimulus(32'hFFFFF8AB, 1'b1, 1'b0, 4'b0110, 4'b0000);
    sbq.push_back('{8'hC2, 1'b0});
    @(negedge clk);
    checkOutput("ovl_narrow_stb", {28'h0, slv_stb}, 32'h4);
    checkOutput("ovl_wide_stb", {28'h0, slv_stb2}, 32'h2);
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Latched select while the address moves, with a stray ack and a stall.
    doReset();
    nextCycle();
    applyStimulus(32'hFFFF1234, 1'b1, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("lat_c1_stb", {28'h0, slv_stb}, 32'h1);
    checkOutput("lat_c1_ack", {31'h0, ack}, 32'h0);
    nextCycle();
    applyStimulus(32'hFFFFF800, 1'b1, 1'b0, 4'b0100, 4'b0000);
    @(negedge clk);
    checkOutput("lat_c2_stb", {28'h0, slv_stb}, 32'h1);
    checkOutput("stray_ack", {31'h0, ack}, 32'h0);
    nextCycle();
    applyStimulus(32'hFFFFF800, 1'b1, 1'b0, 4'b0000, 4'b0001);
    @(negedge clk);
    checkOutput("busy_stall", {31'h0, stall}, 32'h1);
    checkOutput("lat_c3_stb", {28'h0, slv_stb}, 32'h1);
    nextCycle();
    applyStimulus(32'hFFFFF800, 1'b1, 1'b0, 4'b0001, 4'b0000);
    sbq.push_back('{8'hA0, 1'b0});
    @(negedge clk);
    checkOutput("lat_c4_ack", {31'h0, ack}, 32'h1);
    checkOutput("lat_c4_err", {31'h0, err}, 32'h0);
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("lat_done_ack", {31'h0, ack}, 32'h0);

    // Strobe dropped mid-transfer aborts back to live decoding.
    nextCycle();
    applyStimulus(32'hFFFF1234, 1'b1, 1'b0, 4'b0000, 4'b0000);
    nextCycle();
    applyStimulus(32'hFFFF1234, 1'b0, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("abort_stb", {28'h0, slv_stb}, 32'h0);
    checkOutput("abort_err", {31'h0, err}, 32'h0);
    nextCycle();
    applyStimulus(32'hFFFFF004, 1'b1, 1'b0, 4'b0010, 4'b0000);
    sbq.push_back('{8'h5A, 1'b0});
    @(negedge clk);
    checkOutput("abort_idle_stb", {28'h0, slv_stb}, 32'h2);
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Reset while busy returns straight to idle with no ack.
    nextCycle();
    applyStimulus(32'hFFFF1234, 1'b1, 1'b0, 4'b0000, 4'b0000);
    nextCycle();
    applyStimulus(32'hFFFF1234, 1'b1, 1'b0, 4'b0000, 4'b0001);
    @(negedge clk);
    checkOutput("busy_stall2", {31'h0, stall}, 32'h1);
    reset_n = 1'b0;
    nextCycle();
    applyStimulus(32'hFFFFF004, 1'b1, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("rst_busy_stb", {28'h0, slv_stb}, 32'h2);
    checkOutput("rst_busy_ack", {31'h0, ack}, 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    reset_n = 1'b1;

    // Watchdog: first fault captured, second ignored, set beats clear.
    doReset();
    runTimeout(TO_ADR, 1'b1, 256, 1'b0, "to1");
    checkOutput("to1_fault_valid", {31'h0, fault_valid}, 32'h1);
    checkOutput("to1_fault_adr", fault_adr, TO_ADR);
    checkOutput("to1_fault_we", {31'h0, fault_we}, 32'h1);
    runTimeout(TO_ADR ^ 32'h1000, 1'b0, 256, 1'b0, "to2");
    checkOutput("to2_fault_valid", {31'h0, fault_valid}, 32'h1);
    checkOutput("to2_fault_adr", fault_adr, TO_ADR);
    checkOutput("to2_fault_we", {31'h0, fault_we}, 32'h1);
    runTimeout(TO_ADR ^ 32'h2000, 1'b0, 256, 1'b1, "to3");
    checkOutput("to3_fault_valid", {31'h0, fault_valid}, 32'h1);
    checkOutput("to3_fault_adr", fault_adr, TO_ADR ^ 32'h2000);
    checkOutput("to3_fault_we", {31'h0, fault_we}, 32'h0);
    nextCycle();
    fault_clr = 1'b1;
    nextCycle();
    fault_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_fault_valid", {31'h0, fault_valid}, 32'h0);

`ifdef WB8_INTERCONNECT_UNMAPPED_ERR_EN
    // Unmapped address takes the error path on the following cycle.
    doReset();
    runTimeout(32'h40000000, 1'b1, 2, 1'b0, "unmap");
    checkOutput("unmap_fault_valid", {31'h0, fault_valid}, 32'h1);
    checkOutput("unmap_fault_adr", fault_adr, 32'h40000000);
`endif

    nextCycle();
    @(negedge clk);
    checkOutput("sb_empty", sbq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
